// File: rtl/delay_train_pkg.sv
// Shared types and helpers for the delay-line tap trainer.
package delay_train_pkg;

  localparam int unsigned DLY_W   = 4;
  localparam int unsigned DLY_MAX = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_PROBE,
    ST_LISTEN,
    ST_ADJUST,
    ST_SETTLE,
    ST_DONE
  } dt_state_t;

  // Number of increments taking the line from meas to target, modulo line length.
  function automatic logic [DLY_W-1:0] dly_diff(input logic [DLY_W-1:0] target,
                                                input logic [DLY_W-1:0] meas);
    return target - meas;
  endfunction

endpackage

// File: rtl/delay_probe_meas.sv
// Flush / single-probe / listen engine: measures the delay line's current length.
module delay_probe_meas
  import delay_train_pkg::*;
#(
  parameter int unsigned FLUSH_LEN = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             echo_in,
  output logic             probe_out,
  output logic             meas_valid,
  output logic [DLY_W-1:0] meas,
  output logic             timeout
);

  localparam int unsigned FCNT_W = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

  dt_state_t          phase;
  logic [FCNT_W-1:0]  fcnt;
  logic [DLY_W-1:0]   cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase      <= ST_IDLE;
      fcnt       <= '0;
      cnt        <= '0;
      probe_out  <= 1'b0;
      meas_valid <= 1'b0;
      meas       <= '0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
      case (phase)
        ST_FLUSH: begin
          if (fcnt == FCNT_W'(FLUSH_LEN - 1)) begin
            phase     <= ST_PROBE;
            probe_out <= 1'b1;
          end else begin
            fcnt <= fcnt + FCNT_W'(1);
          end
        end
        // A zero-length line echoes combinationally during the probe cycle itself.
        ST_PROBE: begin
          probe_out <= 1'b0;
          if (echo_in) begin
            meas       <= '0;
            meas_valid <= 1'b1;
            phase      <= ST_IDLE;
          end else begin
            cnt   <= DLY_W'(1);
            phase <= ST_LISTEN;
          end
        end
        ST_LISTEN: begin
          if (echo_in) begin
            meas       <= cnt;
            meas_valid <= 1'b1;
            phase      <= ST_IDLE;
          end else if (cnt == DLY_W'(DLY_MAX)) begin
            timeout <= 1'b1;
            phase   <= ST_IDLE;
          end else begin
            cnt <= cnt + DLY_W'(1);
          end
        end
        default: begin
          if (go) begin
            phase <= ST_FLUSH;
            fcnt  <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/delay_tap_trainer.sv
// Trains a wrapping 16-length delay line to TARGET: measure, pulse the difference, verify.
module delay_tap_trainer
  import delay_train_pkg::*;
#(
  parameter int unsigned TARGET    = 8,
  parameter int unsigned FLUSH_LEN = 16,
  parameter int unsigned SETTLE    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             echo_in,
  output logic             probe_out,
  output logic             inc_pulse,
  output logic             busy,
  output logic             done,
  output logic             locked,
  output logic             err,
  output logic [DLY_W-1:0] meas_len
);

  localparam logic [DLY_W-1:0] TGT    = DLY_W'(TARGET);
  localparam int unsigned      SCNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  dt_state_t          state;
  logic               verify_pass;
  logic [DLY_W-1:0]   remaining;
  logic [SCNT_W-1:0]  scnt;

  logic               go_c;
  logic               settle_last_c;
  logic               meas_valid;
  logic               timeout;
  logic [DLY_W-1:0]   meas;

  assign settle_last_c = (scnt == SCNT_W'(SETTLE - 1));
  assign go_c = ((state == ST_IDLE) && start) ||
                ((state == ST_SETTLE) && settle_last_c && (remaining == '0));

  delay_probe_meas #(
    .FLUSH_LEN (FLUSH_LEN)
  ) u_probe (
    .clk        (clk),
    .rst        (rst),
    .go         (go_c),
    .echo_in    (echo_in),
    .probe_out  (probe_out),
    .meas_valid (meas_valid),
    .meas       (meas),
    .timeout    (timeout)
  );

  assign meas_len = meas;

  // ST_FLUSH here spans the whole probe engine run; its sub-phases live in u_probe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      verify_pass <= 1'b0;
      remaining   <= '0;
      scnt        <= '0;
      inc_pulse   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      locked      <= 1'b0;
      err         <= 1'b0;
    end else begin
      inc_pulse <= 1'b0;
      done      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_FLUSH;
            busy        <= 1'b1;
            locked      <= 1'b0;
            err         <= 1'b0;
            verify_pass <= 1'b0;
          end
        end
        ST_FLUSH: begin
          if (timeout) begin
            err   <= 1'b1;
            state <= ST_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else if (meas_valid) begin
            if (verify_pass) begin
              locked <= (meas == TGT);
              err    <= (meas != TGT);
              state  <= ST_DONE;
              done   <= 1'b1;
              busy   <= 1'b0;
            end else if (dly_diff(TGT, meas) == '0) begin
              locked <= 1'b1;
              state  <= ST_DONE;
              done   <= 1'b1;
              busy   <= 1'b0;
            end else begin
              remaining <= dly_diff(TGT, meas);
              inc_pulse <= 1'b1;
              state     <= ST_ADJUST;
            end
          end
        end
        ST_ADJUST: begin
          remaining <= remaining - DLY_W'(1);
          scnt      <= '0;
          state     <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_last_c) begin
            if (remaining != '0) begin
              inc_pulse <= 1'b1;
              state     <= ST_ADJUST;
            end else begin
              verify_pass <= 1'b1;
              state       <= ST_FLUSH;
            end
          end else begin
            scnt <= scnt + SCNT_W'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_delay_tap_trainer.sv
// Bench for delay_tap_trainer: wrapping delay-line model plus an event-timeline reference.
module tb_delay_tap_trainer;

  localparam int TARGET    = 8;
  localparam int FLUSH_LEN = 16;
  localparam int SETTLE    = 2;
  localparam int MAXC      = 4000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       echo_in;
  logic       probe_out, inc_pulse, busy, done, locked, err;
  logic [3:0] meas_len;

  always #5 clk = ~clk;

  delay_tap_trainer #(
    .TARGET    (TARGET),
    .FLUSH_LEN (FLUSH_LEN),
    .SETTLE    (SETTLE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .echo_in   (echo_in),
    .probe_out (probe_out),
    .inc_pulse (inc_pulse),
    .busy      (busy),
    .done      (done),
    .locked    (locked),
    .err       (err),
    .meas_len  (meas_len)
  );

  // Delay line: length 0 is a wire, otherwise a tap on the probe history.
  logic [3:0]  line_len    = 4'd0;
  logic [15:0] hist        = 16'd0;
  logic        line_dead   = 1'b0;
  logic        drop_arm    = 1'b0;
  logic        drop_used   = 1'b0;
  logic        set_len_req = 1'b0;
  logic [3:0]  set_len_val = 4'd0;

  assign echo_in = line_dead ? 1'b0 :
                   (line_len == 4'd0) ? probe_out : hist[line_len - 4'd1];

  always @(posedge clk) begin
    hist <= {hist[14:0], probe_out};
    if (set_len_req) line_len <= set_len_val;
    else if (inc_pulse && !(drop_arm && !drop_used)) line_len <= line_len + 4'd1;
    if (!drop_arm) drop_used <= 1'b0;
    else if (inc_pulse) drop_used <= 1'b1;
  end

  bit       e_busy [MAXC];
  bit       e_done [MAXC];
  bit       e_lock [MAXC];
  bit       e_err  [MAXC];
  bit       e_inc  [MAXC];
  bit       e_probe[MAXC];
  logic [3:0] e_meas [MAXC];

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  int done_seen = 0;
  int inc_seen = 0;
  int last_done_cyc = -1;
  int plan_done = 0;
  int plan_first_inc = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // One clock cycle: compare every output against the timeline, then advance.
  task automatic step();
    logic [9:0] a, e;
    @(negedge clk);
    if (cyc >= 1 && cyc < MAXC) begin
      a = {busy, done, locked, err, inc_pulse, probe_out, meas_len};
      e = {e_busy[cyc], e_done[cyc], e_lock[cyc], e_err[cyc], e_inc[cyc], e_probe[cyc], e_meas[cyc]};
      n_checks++;
      if (a === e) n_pass++;
      else $display("FAIL outputs cycle %0d: got busy,done,lock,err,inc,probe=%b meas=%0d expected %b meas=%0d",
                    cyc, a[9:4], a[3:0], e[9:4], e[3:0]);
    end
    if (done === 1'b1) begin
      done_seen++;
      last_done_cyc = cyc;
    end
    if (inc_pulse === 1'b1) inc_seen++;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Timeline of a training run started (start sampled) in cycle c0 on a line of length L.
  task automatic plan_run(input int c0, input int L, input bit dead, input int drop);
    int p1, m1, n, L2, p2, m2, done_c, last_inc;
    bit lk, er;
    logic [3:0] mprev;
    mprev = e_meas[c0];
    p1 = c0 + FLUSH_LEN + 1;
    m1 = -1; m2 = -1; p2 = -1; n = 0; L2 = 0; last_inc = -1;
    if (dead) begin
      done_c = p1 + 17;
      lk = 1'b0; er = 1'b1;
    end else begin
      m1 = p1 + L + 1;
      n  = (TARGET - L + 16) % 16;
      if (n == 0) begin
        done_c = m1 + 1;
        lk = 1'b1; er = 1'b0;
      end else begin
        L2       = (L + n - drop + 16) % 16;
        last_inc = m1 + 1 + (n - 1) * (SETTLE + 1);
        p2       = last_inc + SETTLE + FLUSH_LEN + 1;
        m2       = p2 + L2 + 1;
        done_c   = m2 + 1;
        lk = (L2 == TARGET); er = !lk;
      end
    end
    plan_done = done_c;
    plan_first_inc = m1 + 1;
    for (int k = c0 + 1; k < MAXC; k++) begin
      e_busy[k]  = (k < done_c);
      e_done[k]  = (k == done_c);
      e_lock[k]  = (k >= done_c) && lk;
      e_err[k]   = (k >= done_c) && er;
      e_probe[k] = (k == p1) || (k == p2);
      e_inc[k]   = (n > 0) && (k >= m1 + 1) && (k <= last_inc) && (((k - m1 - 1) % (SETTLE + 1)) == 0);
      e_meas[k]  = (m2 >= 0 && k >= m2) ? 4'(L2) : (m1 >= 0 && k >= m1) ? 4'(L) : mprev;
    end
  endtask

  task automatic model_reset(input int r);
    for (int k = r + 1; k < MAXC; k++) begin
      e_busy[k] = 0; e_done[k] = 0; e_lock[k] = 0; e_err[k] = 0;
      e_inc[k] = 0; e_probe[k] = 0; e_meas[k] = 4'd0;
    end
  endtask

  task automatic begin_run(input int L_set, input bit dead, input int drop, output int c0);
    if (L_set >= 0) begin
      set_len_val = 4'(L_set);
      set_len_req = 1'b1;
      step();
      set_len_req = 1'b0;
    end
    line_dead = dead;
    drop_arm  = (drop != 0);
    start = 1'b1;
    c0 = cyc;
    plan_run(c0, int'(line_len), dead, drop);
    step();
    start = 1'b0;
  endtask

  task automatic wait_done();
    while (cyc <= plan_done + 1) step();
    line_dead = 1'b0;
    drop_arm  = 1'b0;
  endtask

  task automatic finish_run(input string nm, input int c0, input int exp_off, input int exp_incs,
                            input int exp_meas, input int exp_lock, input int exp_err,
                            input int done0, input int inc0);
    if (exp_off >= 0) begin
      check({nm, "_model_done_off"}, plan_done - c0, exp_off);
      check({nm, "_done_off"}, last_done_cyc - c0, exp_off);
    end else begin
      check({nm, "_done_cyc"}, last_done_cyc, plan_done);
    end
    check({nm, "_inc_count"}, inc_seen - inc0, exp_incs);
    check({nm, "_done_count"}, done_seen - done0, 1);
    check({nm, "_meas_len"}, int'(meas_len), exp_meas);
    check({nm, "_locked"}, int'(locked), exp_lock);
    check({nm, "_err"}, int'(err), exp_err);
  endtask

  initial begin
    int c0, d0, i0, L, n, tgt, pc;
    for (int k = 0; k < MAXC; k++) begin
      e_busy[k] = 0; e_done[k] = 0; e_lock[k] = 0; e_err[k] = 0;
      e_inc[k] = 0; e_probe[k] = 0; e_meas[k] = 4'd0;
    end
    @(posedge clk);
    cyc = 1;
    #1;
    step();
    step();
    rst = 1'b0;
    repeat (3) step();
    check("reset_busy", int'(busy), 0);
    check("reset_meas", int'(meas_len), 0);

    // Zero-length line, with a stray start during the first settle window.
    d0 = done_seen; i0 = inc_seen;
    begin_run(0, 1'b0, 0, c0);
    while (cyc < plan_first_inc + 1) step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done();
    finish_run("len0", c0, 69, 8, 8, 1, 0, d0, i0);

    // Wrap-around: 11 -> 8 needs 13 increments through 15->0.
    d0 = done_seen; i0 = inc_seen;
    begin_run(11, 1'b0, 0, c0);
    wait_done();
    finish_run("wrap11", c0, 95, 13, 8, 1, 0, d0, i0);

    // Already at target: no adjust, no verify.
    d0 = done_seen; i0 = inc_seen;
    begin_run(8, 1'b0, 0, c0);
    wait_done();
    finish_run("at_target", c0, 27, 0, 8, 1, 0, d0, i0);

    // Dead line: timeout, meas_len keeps the previous measurement.
    d0 = done_seen; i0 = inc_seen;
    begin_run(-1, 1'b1, 0, c0);
    wait_done();
    finish_run("no_echo", c0, 34, 0, 8, 0, 1, d0, i0);

    // Line swallows one increment: verify reads 7.
    d0 = done_seen; i0 = inc_seen;
    begin_run(0, 1'b0, 1, c0);
    wait_done();
    finish_run("dropped", c0, 68, 8, 7, 0, 1, d0, i0);

    // Reset on the third increment, then retrain from the line's real length.
    begin_run(2, 1'b0, 0, c0);
    tgt = plan_first_inc + 2 * (SETTLE + 1);
    while (cyc < tgt) step();
    check("rst_at_inc", int'(inc_pulse), 1);
    rst = 1'b1;
    model_reset(cyc);
    step();
    rst = 1'b0;
    check("rst_busy", int'(busy), 0);
    check("rst_meas", int'(meas_len), 0);
    check("rst_line_len", int'(line_len), 5);
    step();
    d0 = done_seen; i0 = inc_seen;
    begin_run(-1, 1'b0, 0, c0);
    wait_done();
    finish_run("after_rst", c0, 59, 3, 8, 1, 0, d0, i0);

    // Random starting lengths with ignored start pulses while busy.
    for (int r = 0; r < 6; r++) begin
      L = $urandom_range(15, 0);
      n = (TARGET - L + 16) % 16;
      d0 = done_seen; i0 = inc_seen;
      begin_run(L, 1'b0, 0, c0);
      pc = c0 + $urandom_range(plan_done - c0 - 1, 2);
      while (cyc < pc) step();
      start = 1'b1;
      step();
      start = 1'b0;
      wait_done();
      finish_run($sformatf("rand%0d_L%0d", r, L), c0, -1, n, TARGET, 1, 0, d0, i0);
    end

    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
